// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares the single-port data memory between the core load/store
// path and a debug/loader master. Core has priority; a saturating hold counter
// guarantees the debug port a grant after MAX_HOLD contested core grants.
module dmem_arbiter #(
  parameter int unsigned ADDR_W   = 32,
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned MAX_HOLD = 4
) (
  input  logic              clk,
  input  logic              rst,
  // core port
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_gnt,
  output logic              cpu_stall,
  output logic              cpu_rvalid,
  output logic [DATA_W-1:0] cpu_rdata,
  // debug port
  input  logic              dbg_req,
  input  logic              dbg_we,
  input  logic [ADDR_W-1:0] dbg_addr,
  input  logic [DATA_W-1:0] dbg_wdata,
  output logic              dbg_gnt,
  output logic              dbg_rvalid,
  output logic [DATA_W-1:0] dbg_rdata,
  // memory side
  output logic              mem_MemRW,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_write_data,
  input  logic [DATA_W-1:0] mem_read_data
);

  localparam logic [3:0] MaxHold = 4'(MAX_HOLD);

  logic [3:0]        hold_cnt_q, hold_cnt_d;
  logic              grant_cpu, grant_dbg;
  logic              cpu_rvalid_q, dbg_rvalid_q;
  logic [DATA_W-1:0] cpu_rdata_q, dbg_rdata_q;

  // Grant decision: debug wins when the core is idle or the hold budget is spent
  always_comb begin
    grant_cpu = 1'b0;
    grant_dbg = 1'b0;
    if (!rst) begin
      if (dbg_req && (!cpu_req || hold_cnt_q == MaxHold)) begin
        grant_dbg = 1'b1;
      end else if (cpu_req) begin
        grant_cpu = 1'b1;
      end
    end
  end

  // Memory drive: granted requester owns the bus, otherwise everything is zero
  always_comb begin
    mem_MemRW      = 1'b0;
    mem_addr       = '0;
    mem_write_data = '0;
    if (grant_cpu) begin
      mem_MemRW      = cpu_we;
      mem_addr       = cpu_addr;
      mem_write_data = cpu_wdata;
    end else if (grant_dbg) begin
      mem_MemRW      = dbg_we;
      mem_addr       = dbg_addr;
      mem_write_data = dbg_wdata;
    end
  end

  // Hold counter next state: counts core grants taken while debug is waiting
  always_comb begin
    hold_cnt_d = hold_cnt_q;
    if (grant_dbg || !dbg_req) begin
      hold_cnt_d = 4'd0;
    end else if (grant_cpu && hold_cnt_q != MaxHold) begin
      hold_cnt_d = hold_cnt_q + 4'd1;
    end
  end

  // State registers: hold counter and per-requester load return
  always_ff @(posedge clk) begin
    if (rst) begin
      hold_cnt_q   <= 4'd0;
      cpu_rvalid_q <= 1'b0;
      dbg_rvalid_q <= 1'b0;
      cpu_rdata_q  <= '0;
      dbg_rdata_q  <= '0;
    end else begin
      hold_cnt_q   <= hold_cnt_d;
      cpu_rvalid_q <= grant_cpu & ~cpu_we;
      dbg_rvalid_q <= grant_dbg & ~dbg_we;
      if (grant_cpu && !cpu_we) begin
        cpu_rdata_q <= mem_read_data;
      end
      if (grant_dbg && !dbg_we) begin
        dbg_rdata_q <= mem_read_data;
      end
    end
  end

  assign cpu_gnt    = grant_cpu;
  assign dbg_gnt    = grant_dbg;
  // Gated by rst so the stall reads 0 while the arbiter is held in reset
  assign cpu_stall  = cpu_req & ~grant_cpu & ~rst;
  assign cpu_rvalid = cpu_rvalid_q;
  assign cpu_rdata  = cpu_rdata_q;
  assign dbg_rvalid = dbg_rvalid_q;
  assign dbg_rdata  = dbg_rdata_q;

endmodule
